mem_arbiter: RTL and testbench

// - Shares one 128-bit line-granular memory port between the I-cache and the D-cache.
// - Sits directly downstream of both caches. Upstream of the off-chip memory model or controller.
// - Serves one line transaction (read refill or write-back) at a time. Routes mem_ready/rdata back to the winner.
// - Absorbs the caches' registered-ready deassertion without issuing duplicate transactions.

---
 rtl/mem_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 517 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one line-granular memory port between the I-cache and the D-cache.
//   One line transaction (read refill or write-back) is in flight at a time.
//   The winner's address, write line and opcode are latched. They are held on
//   the memory port until mem_ready. The completion is then returned to the
//   owner only, as a one-cycle ready pulse plus the read line.
//
//   Each cache registers ready and so drops its request one cycle late. For
//   that reason a master's request is masked in its ready cycle and in the
//   cycle after it (holdoff). This prevents a duplicate transaction.
//
// Configuration macro: ARB_RR_EN
//   defined   : ties are resolved round-robin (the master not granted last wins)
//   undefined : D wins ties. I is forced through after STARVE_LIM consecutive
//               D grants made while I was waiting (default build).
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   i_read, i_write     I-cache line request (level, held until i_ready)
//   i_addr, i_wdata     I-cache line address / write-back line
//   i_rdata, i_ready    line returned to I-cache / 1-cycle completion pulse
//   d_*                 same set for the D-cache
//   mem_read, mem_write memory request, held until mem_ready
//   mem_addr, mem_wdata latched address / write line of current transaction
//   mem_rdata, mem_ready memory read line / completion pulse
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 28,
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    // I-cache side
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    // D-cache side
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    // memory side
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_I_BUSY = 2'd1,
        ST_D_BUSY = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_mem_read;
    logic                r_mem_write;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_i_ready;
    logic                r_d_ready;
    logic [DATA_W-1:0]   r_i_rdata;
    logic [DATA_W-1:0]   r_d_rdata;
    logic                r_hold_i;
    logic                r_hold_d;

    logic                w_idle;
    logic                w_qi;
    logic                w_qd;
    logic                w_pick_d;
    logic                w_grant_i;
    logic                w_grant_d;
    logic                w_win_write;
    logic [ADDR_W-1:0]   w_win_addr;
    logic [DATA_W-1:0]   w_win_wdata;

    assign w_idle = (r_state == ST_IDLE);

    // Qualified requests. The ready cycle and the following cycle are masked
    // because the cache still shows its old request during both of them.
    assign w_qi = (i_read | i_write) & ~(r_i_ready | r_hold_i);
    assign w_qd = (d_read | d_write) & ~(r_d_ready | r_hold_d);

`ifdef ARB_RR_EN
    // Round-robin tie break: remembers which master was granted last.
    logic r_last_d;

    assign w_pick_d = ~w_qi | ~r_last_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_d <= 1'b0;
        end else if (w_grant_d) begin
            r_last_d <= 1'b1;
        end else if (w_grant_i) begin
            r_last_d <= 1'b0;
        end
    end
`else
    // Fixed D priority, bounded by a saturating starvation counter for I.
    localparam int unsigned STARVE_W = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;

    logic [STARVE_W-1:0] r_starve;
    logic                w_starve_sat;

    assign w_starve_sat = (r_starve >= STARVE_W'(STARVE_LIM));
    assign w_pick_d     = ~w_qi | ~w_starve_sat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (w_grant_i) begin
            r_starve <= '0;
        end else if (w_grant_d && w_qi && !w_starve_sat) begin
            r_starve <= r_starve + STARVE_W'(1);
        end
    end
`endif

    assign w_grant_d = w_idle & w_qd & w_pick_d;
    assign w_grant_i = w_idle & w_qi & ~w_grant_d;

    // Winner's payload. Write beats read when both are raised, so that a
    // write-back goes out ahead of its refill.
    assign w_win_write = w_grant_d ? d_write : i_write;
    assign w_win_addr  = w_grant_d ? d_addr  : i_addr;
    assign w_win_wdata = w_grant_d ? d_wdata : i_wdata;

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_ready   <= 1'b0;
            r_d_ready   <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_hold_i    <= 1'b0;
            r_hold_d    <= 1'b0;
        end else begin
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            r_hold_i  <= r_i_ready;
            r_hold_d  <= r_d_ready;

            case (r_state)
                ST_IDLE: begin
                    // mem_ready is ignored here: no transaction is owned
                    if (w_grant_i || w_grant_d) begin
                        r_mem_addr  <= w_win_addr;
                        r_mem_wdata <= w_win_wdata;
                        r_mem_write <= w_win_write;
                        r_mem_read  <= ~w_win_write;
                        r_state     <= w_grant_d ? ST_D_BUSY : ST_I_BUSY;
                    end
                end

                ST_I_BUSY: begin
                    if (mem_ready) begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_i_ready   <= 1'b1;
                        if (r_mem_read) begin
                            r_i_rdata <= mem_rdata;
                        end
                        r_state     <= ST_IDLE;
                    end
                end

                ST_D_BUSY: begin
                    if (mem_ready) begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_d_ready   <= 1'b1;
                        if (r_mem_read) begin
                            r_d_rdata <= mem_rdata;
                        end
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                end
            endcase
        end
    end

    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign i_ready   = r_i_ready;
    assign d_ready   = r_d_ready;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;

    // A memory request is outstanding exactly when a master owns the port.
    a_busy_has_op: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state != ST_IDLE) == (r_mem_read | r_mem_write));

    a_op_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        !(r_mem_read && r_mem_write));

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        !(r_i_ready && r_d_ready));

    // The latched transaction stays frozen until memory completes it.
    a_payload_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state != ST_IDLE && !mem_ready) |=>
            ($stable(r_mem_addr) && $stable(r_mem_wdata) && $stable(r_mem_write)));

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter. A small memory responder raises mem_ready
//   after a programmable number of cycles, or the bench drives it by hand.
//   A monitor logs each issued memory transaction (op, addr, wdata).
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int unsigned ADDR_W = 28;
    localparam int unsigned DATA_W = 128;
`ifdef ARB_RR_EN
    localparam int unsigned STARVE_EXP = 1;
`else
    localparam int unsigned STARVE_EXP = 4;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_read, i_write, d_read, d_write;
    logic [ADDR_W-1:0] i_addr, d_addr;
    logic [DATA_W-1:0] i_wdata, d_wdata;
    logic [DATA_W-1:0] i_rdata, d_rdata;
    logic              i_ready, d_ready;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    // memory responder controls
    bit                resp_en;
    int                resp_lat;
    int                resp_cnt;
    logic              auto_ready;
    logic              man_ready;
    logic [DATA_W-1:0] rd_line;

    // transaction log
    logic              prev_act;
    int                log_n;
    logic              log_op [32];
    logic [ADDR_W-1:0] log_addr [32];
    logic [DATA_W-1:0] log_wdata [32];

    int checks;
    int errors;

    always #5 clk = ~clk;

    assign mem_ready = resp_en ? auto_ready : man_ready;
    assign mem_rdata = rd_line;

    mem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_read    (i_read),
        .i_write   (i_write),
        .i_addr    (i_addr),
        .i_wdata   (i_wdata),
        .i_rdata   (i_rdata),
        .i_ready   (i_ready),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    // Memory responder: one-cycle mem_ready pulse after resp_lat request cycles.
    always @(posedge clk) begin
        #1;
        if (!resp_en) begin
            auto_ready = 1'b0;
            resp_cnt   = 0;
        end else if (auto_ready) begin
            auto_ready = 1'b0;
            resp_cnt   = 0;
        end else if (mem_read || mem_write) begin
            if (resp_cnt + 1 >= resp_lat) auto_ready = 1'b1;
            else resp_cnt++;
        end else begin
            resp_cnt = 0;
        end
    end

    // Transaction monitor: logs each new memory request on its first cycle.
    always @(posedge clk) begin
        #1;
        if ((mem_read || mem_write) && !prev_act && log_n < 32) begin
            log_op[log_n]    = mem_write;
            log_addr[log_n]  = mem_addr;
            log_wdata[log_n] = mem_wdata;
            log_n++;
        end
        prev_act = mem_read || mem_write;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Waits for i_ready (0), d_ready (1) or any memory request (2).
    task automatic wait_for(input int sel, input int budget, output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        while (!ok && cyc < budget) begin
            @(negedge clk);
            cyc++;
            case (sel)
                0:       ok = (i_ready === 1'b1);
                1:       ok = (d_ready === 1'b1);
                default: ok = (mem_read === 1'b1) || (mem_write === 1'b1);
            endcase
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(2);
        checks++;
        if ({mem_read, mem_write, i_ready, d_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctl: got %b expected 0000", {mem_read, mem_write, i_ready, d_ready});
        end
        checks++;
        if (mem_addr !== '0) begin
            errors++;
            $display("FAIL reset_addr: got %h expected 0", mem_addr);
        end
        checks++;
        if (mem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_wdata: got %h expected 0", mem_wdata);
        end
        checks++;
        if (i_rdata !== '0 || d_rdata !== '0) begin
            errors++;
            $display("FAIL reset_rdata: got i=%h d=%h expected 0", i_rdata, d_rdata);
        end
        rst_n = 1'b1;
        tick(2);
        checks++;
        if ({mem_read, mem_write} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: got %b expected 00", {mem_read, mem_write});
        end
    endtask

    task automatic test_single_read();
        bit   ok;
        int   cyc;
        int   base;
        logic seen_d;
        resp_en  = 1'b1;
        resp_lat = 3;
        rd_line  = {16{8'hA5}};
        base     = log_n;
        i_addr   = 28'h0000010;
        i_read   = 1'b1;
        tick(1);
        checks++;
        if ({mem_read, mem_write} !== 2'b10) begin
            errors++;
            $display("FAIL single_op: got %b expected 10", {mem_read, mem_write});
        end
        checks++;
        if (mem_addr !== 28'h0000010) begin
            errors++;
            $display("FAIL single_addr: got %h expected 0000010", mem_addr);
        end
        seen_d = 1'b0;
        ok     = 1'b0;
        cyc    = 0;
        while (!ok && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (d_ready !== 1'b0) seen_d = 1'b1;
            ok = (i_ready === 1'b1);
        end
        checks++;
        if (!ok || cyc != 3) begin
            errors++;
            $display("FAIL single_latency: got ok=%0d cyc=%0d expected ok=1 cyc=3", ok, cyc);
        end
        checks++;
        if (i_rdata !== {16{8'hA5}}) begin
            errors++;
            $display("FAIL single_rdata: got %h expected a5..a5", i_rdata);
        end
        checks++;
        if (seen_d) begin
            errors++;
            $display("FAIL single_d_ready: got 1 expected 0");
        end
        tick(1);
        i_read = 1'b0;
        checks++;
        if ({i_ready, mem_read} !== 2'b00) begin
            errors++;
            $display("FAIL single_pulse: got %b expected 00", {i_ready, mem_read});
        end
        tick(2);
        checks++;
        if (log_n - base != 1) begin
            errors++;
            $display("FAIL single_count: got %0d expected 1", log_n - base);
        end
    endtask

    task automatic test_holdoff();
        bit ok;
        int cyc;
        int base;
        resp_lat = 1;
        rd_line  = {4{32'h1111_2222}};
        base     = log_n;
        i_addr   = 28'h0000020;
        i_read   = 1'b1;
        wait_for(0, 20, ok, cyc);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL holdoff_ready: got timeout expected i_ready");
        end
        checks++;
        if (i_rdata !== {4{32'h1111_2222}}) begin
            errors++;
            $display("FAIL holdoff_rdata: got %h expected 11112222x4", i_rdata);
        end
        tick(1);
        checks++;
        if (mem_read !== 1'b0) begin
            errors++;
            $display("FAIL holdoff_c1: got mem_read=%b expected 0", mem_read);
        end
        tick(1);
        i_read = 1'b0;
        checks++;
        if (mem_read !== 1'b0) begin
            errors++;
            $display("FAIL holdoff_c2: got mem_read=%b expected 0", mem_read);
        end
        tick(2);
        checks++;
        if (log_n - base != 1) begin
            errors++;
            $display("FAIL holdoff_count: got %0d expected 1", log_n - base);
        end
    endtask

    task automatic test_tie();
        bit ok;
        int cyc;
        int base;
        resp_lat = 2;
        rd_line  = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        base     = log_n;
        i_addr   = 28'h0000100;
        i_read   = 1'b1;
        d_addr   = 28'h0000200;
        d_wdata  = {4{32'hDEAD_BEEF}};
        d_write  = 1'b1;
        tick(1);
        checks++;
        if ({mem_read, mem_write} !== 2'b01 || mem_addr !== 28'h0000200) begin
            errors++;
            $display("FAIL tie_first: got op=%b addr=%h expected op=01 addr=0000200",
                     {mem_read, mem_write}, mem_addr);
        end
        wait_for(1, 20, ok, cyc);
        checks++;
        if (!ok || i_ready !== 1'b0) begin
            errors++;
            $display("FAIL tie_d_ready: got ok=%0d i_ready=%b expected ok=1 i_ready=0", ok, i_ready);
        end
        checks++;
        if (d_rdata !== '0) begin
            errors++;
            $display("FAIL tie_wr_rdata: got %h expected 0", d_rdata);
        end
        tick(1);
        d_write = 1'b0;
        wait_for(0, 20, ok, cyc);
        checks++;
        if (!ok || i_rdata !== 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677) begin
            errors++;
            $display("FAIL tie_i_done: got ok=%0d rdata=%h expected ok=1 rdata=0123..6677", ok, i_rdata);
        end
        tick(1);
        i_read = 1'b0;
        tick(3);
        checks++;
        if (log_n - base != 2) begin
            errors++;
            $display("FAIL tie_count: got %0d expected 2", log_n - base);
        end else begin
            checks++;
            if (log_op[base] !== 1'b1 || log_addr[base] !== 28'h0000200 ||
                log_wdata[base] !== {4{32'hDEAD_BEEF}}) begin
                errors++;
                $display("FAIL tie_txn0: got op=%b addr=%h wdata=%h expected op=1 addr=0000200 wdata=deadbeef x4",
                         log_op[base], log_addr[base], log_wdata[base]);
            end
            checks++;
            if (log_op[base+1] !== 1'b0 || log_addr[base+1] !== 28'h0000100) begin
                errors++;
                $display("FAIL tie_txn1: got op=%b addr=%h expected op=0 addr=0000100",
                         log_op[base+1], log_addr[base+1]);
            end
        end
    endtask

    task automatic test_starve();
        bit                ok;
        int                cyc;
        int                base;
        logic [ADDR_W-1:0] exp_addr;
        resp_lat = 1;
        rd_line  = {4{32'h7777_0000}};
        base     = log_n;
        d_addr   = 28'h0000300;
        d_read   = 1'b1;
        i_addr   = 28'h0000400;
        i_read   = 1'b1;
        for (int k = 0; k <= int'(STARVE_EXP); k++) begin
            if (k > 0) begin
                wait_for(1, 20, ok, cyc);
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL starve_d_ready%0d: got timeout expected d_ready", k);
                end
                // D requalifies two cycles after its ready: raise I into that tie
                tick(2);
                i_read = 1'b1;
            end
            tick(1);
            exp_addr = (k == int'(STARVE_EXP)) ? 28'h0000400 : 28'h0000300;
            checks++;
            if (mem_read !== 1'b1 || mem_addr !== exp_addr) begin
                errors++;
                $display("FAIL starve_grant%0d: got rd=%b addr=%h expected rd=1 addr=%h",
                         k, mem_read, mem_addr, exp_addr);
            end
            if (k < int'(STARVE_EXP)) i_read = 1'b0;
        end
        d_read = 1'b0;
        wait_for(0, 20, ok, cyc);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL starve_i_ready: got timeout expected i_ready");
        end
        tick(1);
        i_read = 1'b0;
        tick(3);
        checks++;
        if (log_n - base != int'(STARVE_EXP) + 1) begin
            errors++;
            $display("FAIL starve_count: got %0d expected %0d", log_n - base, STARVE_EXP + 1);
        end
    endtask

    task automatic test_reset_busy();
        resp_en   = 1'b0;
        man_ready = 1'b0;
        rd_line   = {4{32'hCAFE_F00D}};
        d_addr    = 28'h0000500;
        d_read    = 1'b1;
        tick(1);
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h0000500) begin
            errors++;
            $display("FAIL rstbusy_grant: got rd=%b addr=%h expected rd=1 addr=0000500", mem_read, mem_addr);
        end
        tick(1);
        rst_n  = 1'b0;
        d_read = 1'b0;
        tick(1);
        checks++;
        if ({mem_read, mem_write, i_ready, d_ready} !== 4'b0000 || mem_addr !== '0 ||
            mem_wdata !== '0 || i_rdata !== '0 || d_rdata !== '0) begin
            errors++;
            $display("FAIL rstbusy_clear: got ctl=%b addr=%h i_rdata=%h expected all 0",
                     {mem_read, mem_write, i_ready, d_ready}, mem_addr, i_rdata);
        end
        rst_n     = 1'b1;
        man_ready = 1'b1;
        tick(1);
        man_ready = 1'b0;
        checks++;
        if ({mem_read, mem_write, i_ready, d_ready} !== 4'b0000 || d_rdata !== '0) begin
            errors++;
            $display("FAIL rstbusy_late_ready: got ctl=%b d_rdata=%h expected 0000 and 0",
                     {mem_read, mem_write, i_ready, d_ready}, d_rdata);
        end
        tick(1);
        checks++;
        if ({mem_read, mem_write, i_ready, d_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL rstbusy_after: got %b expected 0000", {mem_read, mem_write, i_ready, d_ready});
        end
    endtask

    task automatic test_write_then_read();
        bit ok;
        int cyc;
        int base;
        resp_en  = 1'b1;
        resp_lat = 3;
        rd_line  = {4{32'hFEED_5A5A}};
        base     = log_n;
        d_addr   = 28'h0000600;
        d_wdata  = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
        d_write  = 1'b1;
        d_read   = 1'b1;
        tick(1);
        checks++;
        if ({mem_read, mem_write} !== 2'b01 || mem_wdata !== 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321) begin
            errors++;
            $display("FAIL wtr_write: got op=%b wdata=%h expected op=01 wdata=1234..4321",
                     {mem_read, mem_write}, mem_wdata);
        end
        d_wdata = ~d_wdata;
        d_addr  = 28'h0000700;
        tick(1);
        checks++;
        if (mem_wdata !== 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321 || mem_addr !== 28'h0000600) begin
            errors++;
            $display("FAIL wtr_stable: got addr=%h wdata=%h expected addr=0000600 wdata=1234..4321",
                     mem_addr, mem_wdata);
        end
        wait_for(1, 20, ok, cyc);
        d_addr = 28'h0000600;
        checks++;
        if (!ok || d_rdata !== '0) begin
            errors++;
            $display("FAIL wtr_wr_done: got ok=%0d d_rdata=%h expected ok=1 d_rdata=0", ok, d_rdata);
        end
        tick(1);
        d_write = 1'b0;
        wait_for(2, 20, ok, cyc);
        checks++;
        if (!ok || mem_read !== 1'b1 || mem_addr !== 28'h0000600) begin
            errors++;
            $display("FAIL wtr_refill: got ok=%0d rd=%b addr=%h expected ok=1 rd=1 addr=0000600",
                     ok, mem_read, mem_addr);
        end
        wait_for(1, 20, ok, cyc);
        checks++;
        if (!ok || d_rdata !== {4{32'hFEED_5A5A}}) begin
            errors++;
            $display("FAIL wtr_rd_done: got ok=%0d d_rdata=%h expected ok=1 d_rdata=feed5a5a x4", ok, d_rdata);
        end
        tick(1);
        d_read = 1'b0;
        tick(2);
        checks++;
        if (log_n - base != 2) begin
            errors++;
            $display("FAIL wtr_count: got %0d expected 2", log_n - base);
        end else begin
            checks++;
            if (log_op[base] !== 1'b1 || log_op[base+1] !== 1'b0) begin
                errors++;
                $display("FAIL wtr_order: got ops %b,%b expected 1,0", log_op[base], log_op[base+1]);
            end
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        i_read     = 1'b0;
        i_write    = 1'b0;
        i_addr     = '0;
        i_wdata    = '0;
        d_read     = 1'b0;
        d_write    = 1'b0;
        d_addr     = '0;
        d_wdata    = '0;
        resp_en    = 1'b0;
        resp_lat   = 1;
        resp_cnt   = 0;
        auto_ready = 1'b0;
        man_ready  = 1'b0;
        rd_line    = '0;
        prev_act   = 1'b0;
        log_n      = 0;

        test_reset();
        test_single_read();
        test_holdoff();
        test_tie();
        test_starve();
        test_reset_busy();
        test_write_then_read();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
